// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
//
// Fractional baud-rate generator for the UART controller. It divides the
// reference clock into two single-cycle clock-enable pulses:
//   - rx_clk_en_o at the oversampling rate, for the RX sampler
//   - tx_clk_en_o at the bit rate, for the TX shifter
// The RX period is baud_div_i + baud_frac_i/2^FRAC_W reference cycles.
// The TX period is 16 or 8 RX periods.
//
// Optional feature macro: UART_BAUD_FRAC_EN
//   - Defined: the fractional accumulator is built and baud_frac_i is used.
//   - Undefined: the block is a pure integer divider and baud_frac_i is
//     ignored.
//
// Ports:
//   uart_clk_i    reference clock (the only clock)
//   uart_rst_n_i  synchronous active-low reset
//   gen_en_i      generator enable; low holds the counters idle
//   baud_div_i    integer part of the RX period, in clock cycles
//   baud_frac_i   fractional part of the RX period, in 1/2^FRAC_W cycles
//   ovs_sel_i     oversampling select: 0 = 16x, 1 = 8x
//   tx_restart_i  one-cycle pulse that realigns the TX bit phase
//   rx_clk_en_o   one-cycle pulse per RX (oversampling) period
//   tx_clk_en_o   one-cycle pulse per bit period, coincident with an RX pulse
//   div_zero_o    high while the shadowed integer divisor is 0

module uart_baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              uart_clk_i,
  input  logic              uart_rst_n_i,
  input  logic              gen_en_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic [FRAC_W-1:0] baud_frac_i,
  input  logic              ovs_sel_i,
  input  logic              tx_restart_i,
  output logic              rx_clk_en_o,
  output logic              tx_clk_en_o,
  output logic              div_zero_o
);

  localparam int CNT_W = DIV_W + 1;

  logic             en_q, en_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic             ovs_sh_q, ovs_sh_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]       tx_cnt_q, tx_cnt_d;
  logic             rx_en_q, rx_en_d;
  logic             tx_en_q, tx_en_d;
  logic             div_zero_q, div_zero_d;

  logic             arm;
  logic             shadow_load;
  logic             period_end;
  logic             carry;
  logic [CNT_W-1:0] period_last;
  logic [3:0]       tx_term;

  // The first enabled cycle only arms the generator: the shadows capture
  // the inputs and the counters stay at 0. With divisor N, the first RX
  // pulse therefore follows the N-th edge after the arming edge.
  // The shadows reload in every cycle that carries an RX pulse. A divisor
  // change made mid-period therefore only affects the following period.
  always_comb begin
    arm         = gen_en_i & ~en_q;
    shadow_load = gen_en_i & (~en_q | rx_en_q);
    // A divisor of 0 behaves as 1. The carry stretches this period by one
    // cycle.
    if (div_sh_q == '0) begin
      period_last = CNT_W'(carry);
    end else begin
      period_last = {1'b0, div_sh_q} - CNT_W'(1) + CNT_W'(carry);
    end
    period_end = gen_en_i & en_q & (rx_cnt_q == period_last);
    tx_term    = ovs_sh_q ? 4'd7 : 4'd15;
  end

  // Next-state logic for the counters, the shadows and the pulses.
  // The TX terminal test is an equality test. If an 8x switch happens while
  // tx_cnt is already above 7, the counter wraps through 15 -> 0 without
  // emitting a TX pulse. A restart pulse overrides a coinciding terminal
  // count.
  always_comb begin
    en_d     = gen_en_i;
    div_sh_d = div_sh_q;
    ovs_sh_d = ovs_sh_q;
    rx_cnt_d = '0;
    tx_cnt_d = '0;
    rx_en_d  = 1'b0;
    tx_en_d  = 1'b0;
    if (shadow_load) begin
      div_sh_d = baud_div_i;
      ovs_sh_d = ovs_sel_i;
    end
    if (gen_en_i && !arm) begin
      rx_cnt_d = period_end ? '0 : rx_cnt_q + CNT_W'(1);
      rx_en_d  = period_end;
      tx_cnt_d = tx_cnt_q;
      if (tx_restart_i) begin
        tx_cnt_d = '0;
      end else if (period_end) begin
        if (tx_cnt_q == tx_term) begin
          tx_cnt_d = '0;
          tx_en_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 4'd1;
        end
      end
    end
    div_zero_d = (div_sh_d == '0);
  end

  // State register. All outputs come straight from these flops.
  always_ff @(posedge uart_clk_i) begin
    if (!uart_rst_n_i) begin
      en_q       <= 1'b0;
      div_sh_q   <= '0;
      ovs_sh_q   <= 1'b0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rx_en_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      div_sh_q   <= div_sh_d;
      ovs_sh_q   <= ovs_sh_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_en_q    <= rx_en_d;
      tx_en_q    <= tx_en_d;
      div_zero_q <= div_zero_d;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic              carry_q, carry_d;

  // The fraction accumulates once per RX period. Its overflow is a carry
  // that lengthens only the next period by one cycle, so the average
  // period is div + frac/2^FRAC_W.
  always_comb begin
    frac_sh_d  = shadow_load ? baud_frac_i : frac_sh_q;
    frac_acc_d = frac_acc_q;
    carry_d    = carry_q;
    if (!gen_en_i || arm) begin
      frac_acc_d = '0;
      carry_d    = 1'b0;
    end else if (period_end) begin
      {carry_d, frac_acc_d} = {1'b0, frac_acc_q} + {1'b0, frac_sh_q};
    end
  end

  // Registers for the fractional accumulator and its shadow.
  always_ff @(posedge uart_clk_i) begin
    if (!uart_rst_n_i) begin
      frac_sh_q  <= '0;
      frac_acc_q <= '0;
      carry_q    <= 1'b0;
    end else begin
      frac_sh_q  <= frac_sh_d;
      frac_acc_q <= frac_acc_d;
      carry_q    <= carry_d;
    end
  end

  assign carry = carry_q;
`else
  logic unused_frac;
  assign unused_frac = ^baud_frac_i;
  assign carry       = 1'b0;
`endif

  assign rx_clk_en_o = rx_en_q;
  assign tx_clk_en_o = tx_en_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac
//
// Directed, self-checking bench for uart_baud_gen_frac. Inputs change 1 ns
// after a rising edge. Outputs are observed at the same point, so "after
// edge e" is the value registered by rising edge e. Edge 0 is the edge that
// first samples gen_en_i high. The fractional scenario reads the
// UART_BAUD_FRAC_EN macro to select its expected values.

module tb_uart_baud_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              gen_en;
  logic [DIV_W-1:0]  baud_div;
  logic [FRAC_W-1:0] baud_frac;
  logic              ovs_sel;
  logic              tx_restart;
  logic              rx_en;
  logic              tx_en;
  logic              div_zero;

  int errors = 0;
  int checks = 0;

  uart_baud_gen_frac #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .uart_clk_i   (clk),
    .uart_rst_n_i (rst_n),
    .gen_en_i     (gen_en),
    .baud_div_i   (baud_div),
    .baud_frac_i  (baud_frac),
    .ovs_sel_i    (ovs_sel),
    .tx_restart_i (tx_restart),
    .rx_clk_en_o  (rx_en),
    .tx_clk_en_o  (tx_en),
    .div_zero_o   (div_zero)
  );

  always #5 clk = ~clk;

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [DIV_W-1:0] div,
                               input logic [FRAC_W-1:0] frac, input logic ovs);
    gen_en    = en;
    baud_div  = div;
    baud_frac = frac;
    ovs_sel   = ovs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Disables the generator for one edge, then arms it with new settings.
  // On return, edge 0 has just happened.
  task automatic rearm(input string tag, input logic [DIV_W-1:0] div,
                       input logic [FRAC_W-1:0] frac, input logic ovs);
    applyStimulus(1'b0, div, frac, ovs);
    tick();
    checkOutput({tag, "_off_rx"}, 32'(rx_en), 32'd0);
    checkOutput({tag, "_off_tx"}, 32'(tx_en), 32'd0);
    applyStimulus(1'b1, div, frac, ovs);
    tick();
  endtask

  initial begin
    int rx_count;
    int exp_count;
    logic rx_at12;
    logic rx_at13;
    logic exp12;
    logic exp13;
    logic exp_rx;
    logic exp_tx;

    // Reset state
    rst_n      = 1'b0;
    tx_restart = 1'b0;
    applyStimulus(1'b0, 16'd4, 4'd0, 1'b0);
    repeat (3) tick();
    checkOutput("reset_rx", 32'(rx_en), 32'd0);
    checkOutput("reset_tx", 32'(tx_en), 32'd0);
    checkOutput("reset_divzero", 32'(div_zero), 32'd0);

    // Basic 16x, div=4
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'd4, 4'd0, 1'b0);
    tick();
    checkOutput("basic_e0_rx", 32'(rx_en), 32'd0);
    checkOutput("basic_e0_divzero", 32'(div_zero), 32'd0);
    for (int e = 1; e <= 128; e++) begin
      tick();
      checkOutput($sformatf("basic_rx@%0d", e), 32'(rx_en), 32'(e % 4 == 0));
      checkOutput($sformatf("basic_tx@%0d", e), 32'(tx_en), 32'(e % 64 == 0));
    end

    // Fractional: div=4, frac=8
    rearm("frac", 16'd4, 4'd8, 1'b0);
    rx_count = 0;
    rx_at12  = 1'b0;
    rx_at13  = 1'b0;
    for (int e = 1; e <= 144; e++) begin
      tick();
      if (rx_en === 1'b1) rx_count++;
      if (e == 12) rx_at12 = rx_en;
      if (e == 13) rx_at13 = rx_en;
    end
`ifdef UART_BAUD_FRAC_EN
    exp_count = 32;
    exp12     = 1'b0;
    exp13     = 1'b1;
`else
    exp_count = 36;
    exp12     = 1'b1;
    exp13     = 1'b0;
`endif
    checkOutput("frac_rx_count", 32'(rx_count), 32'(exp_count));
    checkOutput("frac_rx@12", 32'(rx_at12), 32'(exp12));
    checkOutput("frac_rx@13", 32'(rx_at13), 32'(exp13));

    // 8x, div=10 changed to 3 after edge 15
    rearm("ovs8", 16'd10, 4'd0, 1'b1);
    for (int e = 1; e <= 70; e++) begin
      tick();
      exp_rx = (e == 10) || (e == 20) || (e >= 23 && (e - 23) % 3 == 0);
      exp_tx = (e == 38) || (e == 62);
      checkOutput($sformatf("ovs8_rx@%0d", e), 32'(rx_en), 32'(exp_rx));
      checkOutput($sformatf("ovs8_tx@%0d", e), 32'(tx_en), 32'(exp_tx));
      if (e == 15) baud_div = 16'd3;
    end

    // Restart collision on the 16th RX period end (edge 32, div=2)
    rearm("rst_col", 16'd2, 4'd0, 1'b0);
    for (int e = 1; e <= 66; e++) begin
      tick();
      checkOutput($sformatf("col_rx@%0d", e), 32'(rx_en), 32'(e % 2 == 0));
      checkOutput($sformatf("col_tx@%0d", e), 32'(tx_en), 32'(e == 64));
      if (e == 31) tx_restart = 1'b1;
      if (e == 32) tx_restart = 1'b0;
    end

    // div=0, then div=2
    rearm("dz", 16'd0, 4'd0, 1'b0);
    checkOutput("dz_e0_divzero", 32'(div_zero), 32'd1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput($sformatf("dz_rx@%0d", e), 32'(rx_en), 32'd1);
      checkOutput($sformatf("dz_divzero@%0d", e), 32'(div_zero), 32'd1);
    end
    baud_div = 16'd2;
    for (int e = 6; e <= 12; e++) begin
      tick();
      checkOutput($sformatf("dz2_rx@%0d", e), 32'(rx_en), 32'(e % 2 == 0));
      checkOutput($sformatf("dz2_divzero@%0d", e), 32'(div_zero), 32'd0);
    end

    // Reset, then disable, mid-period with div=6
    rearm("mid", 16'd6, 4'd0, 1'b0);
    for (int e = 1; e <= 32; e++) begin
      tick();
      exp_rx = (e == 10) || (e == 16) || (e == 26) || (e == 32);
      checkOutput($sformatf("mid_rx@%0d", e), 32'(rx_en), 32'(exp_rx));
      checkOutput($sformatf("mid_tx@%0d", e), 32'(tx_en), 32'd0);
      if (e == 3) checkOutput("mid_rst_divzero", 32'(div_zero), 32'd0);
      if (e == 2) rst_n = 1'b0;
      if (e == 3) rst_n = 1'b1;
      if (e == 18) gen_en = 1'b0;
      if (e == 19) gen_en = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
